// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory port arbiter and its neighbours
// (memory wrapper, SoC top level):
//   - master index constants (M_CPU = 0, M_AUX = 1)
//   - default data-memory address / data widths
//   - width of the anti-starvation hold counter and its saturating increment
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // Default widths of the data memory read/write port.
  localparam int unsigned DMEM_AW = 32;
  localparam int unsigned DMEM_DW = 32;

  // Hold counter width; MAX_HOLD is limited to 1..15 so four bits suffice.
  localparam int unsigned HOLD_W = 4;

  // Master indices; also the encoding of the "last winner" register.
  typedef enum logic {
    M_CPU = 1'b0,
    M_AUX = 1'b1
  } master_e;

  // Saturating increment of the hold counter, clamped at max_cnt.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(
    input logic [HOLD_W-1:0] cnt,
    input logic [HOLD_W-1:0] max_cnt
  );
    logic [HOLD_W-1:0] res;
    if (cnt >= max_cnt) begin
      res = max_cnt;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One master's single-cycle access channel to the shared data-memory port.
//   req    master -> arbiter  access request, held with its command until gnt
//   we     master -> arbiter  1 = write, 0 = read
//   addr   master -> arbiter  byte address
//   wdata  master -> arbiter  write data
//   gnt    arbiter -> master  access performed this cycle (combinational)
//   rvalid arbiter -> master  read data valid, one cycle after a granted read
//   rdata  arbiter -> master  registered read data
// Modports: master (requesting side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = DMEM_AW,
  parameter int unsigned DW = DMEM_DW
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational grant decision for the two-master data-memory arbiter.
// A lone requester always wins. On contest:
//   DMEM_ARB_RR_EN defined : the master that did not win last time wins.
//   DMEM_ARB_RR_EN undefined: m0 wins unless hold_cnt has reached MAX_HOLD,
//                             in which case m1 is forced through.
// Ports:
//   req0, req1  in   requests (already masked by reset in the top)
//   last        in   previous winner
//   hold_cnt    in   consecutive contested m0 wins (fixed-priority build only)
//   gnt0, gnt1  out  one-hot-or-zero grant
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              req0,
  input  logic              req1,
  input  master_e           last,
`ifndef DMEM_ARB_RR_EN
  input  logic [HOLD_W-1:0] hold_cnt,
`endif
  output logic              gnt0,
  output logic              gnt1
);

`ifdef DMEM_ARB_RR_EN
  // Round robin ignores the starvation limit; keep it referenced as a constant.
  localparam int unsigned MAX_HOLD_UNUSED = MAX_HOLD;
`else
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
`endif

  // Grant decision from the request pair and arbitration history.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case ({req0, req1})
      2'b10: begin
        gnt0 = 1'b1;
      end
      2'b01: begin
        gnt1 = 1'b1;
      end
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        if (last == M_AUX) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
`else
        if (hold_cnt == MAX_HOLD_C) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`endif
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

`ifndef DMEM_ARB_RR_EN
  // last only matters for round robin; fold it into a no-op in this build.
  logic last_unused_s;
  assign last_unused_s = last;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the data memory's single read/write port between the CPU data path
// (m0) and an auxiliary master (m1, game-state engine / loader). Every cycle
// at most one master is granted a single-cycle access and muxed onto mem_*.
// Read data is captured at the end of the grant cycle and returned to the
// winner with a one-cycle rvalid pulse.
//
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined, m0 has fixed priority with MAX_HOLD anti-starvation for m1.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   m0, m1     slave modports of dmem_arbiter_if (m0 = CPU, m1 = aux)
//   mem_we     out  memory write enable
//   mem_addr   out  memory read/write address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data (combinational read of mem_addr)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DMEM_AW,
  parameter int unsigned DW       = DMEM_DW,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);

  // Requests are masked while reset is low so no grant (and no write) can
  // happen in a cycle that reset is cutting short.
  logic req0_s;
  logic req1_s;
  logic gnt0_s;
  logic gnt1_s;

  master_e       last_q;
  master_e       last_d;
  logic          rvalid0_q;
  logic          rvalid0_d;
  logic          rvalid1_q;
  logic          rvalid1_d;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata0_d;
  logic [DW-1:0] rdata1_q;
  logic [DW-1:0] rdata1_d;
`ifndef DMEM_ARB_RR_EN
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
`endif

  assign req0_s = m0.req & reset;
  assign req1_s = m1.req & reset;

  dmem_arb_pick #(
    .MAX_HOLD (MAX_HOLD)
  ) u_pick (
    .req0     (req0_s),
    .req1     (req1_s),
    .last     (last_q),
`ifndef DMEM_ARB_RR_EN
    .hold_cnt (hold_cnt_q),
`endif
    .gnt0     (gnt0_s),
    .gnt1     (gnt1_s)
  );

  assign m0.gnt    = gnt0_s;
  assign m1.gnt    = gnt1_s;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  // Memory port mux: the granted master's command, all zeros when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0_s) begin
      mem_we    = m0.we;
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
    end else if (gnt1_s) begin
      mem_we    = m1.we;
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Arbitration history: last winner and, in fixed mode, the hold counter.
  always_comb begin
    last_d = last_q;
    if (gnt0_s) begin
      last_d = M_CPU;
    end else if (gnt1_s) begin
      last_d = M_AUX;
    end else begin
      last_d = last_q;
    end
`ifndef DMEM_ARB_RR_EN
    // Counts only contested m0 wins; any m1 win or idle m1 clears it.
    hold_cnt_d = '0;
    if (gnt0_s && m1.req) begin
      hold_cnt_d = hold_sat_inc(hold_cnt_q, HOLD_W'(MAX_HOLD));
    end else begin
      hold_cnt_d = '0;
    end
`endif
  end

  // Read return: capture mem_rdata for the read winner, loser keeps its data.
  always_comb begin
    rvalid0_d = gnt0_s & ~m0.we;
    rvalid1_d = gnt1_s & ~m1.we;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) begin
      rdata0_d = mem_rdata;
    end else if (rvalid1_d) begin
      rdata1_d = mem_rdata;
    end else begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
    end
  end

  // State registers; reset drops any in-flight rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= M_AUX;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifndef DMEM_ARB_RR_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      last_q     <= last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifndef DMEM_ARB_RR_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// reset / hold sequences, then randomized traffic against a reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Simple data memory: combinational read, write at the clock edge.
  bit [31:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
  endtask

  typedef struct {
    logic        r0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic        r1; logic w1; logic [31:0] a1; logic [31:0] d1;
    logic        g0; logic g1;
  } vec_t;

  vec_t vecs [12];

  // Apply one table row: grant/mem checks mid-cycle, rvalid after the edge.
  task automatic run_row(input int i);
    vec_t v;
    v = vecs[i];
    drive0(v.r0, v.w0, v.a0, v.d0);
    drive1(v.r1, v.w1, v.a1, v.d1);
    @(negedge clk);
    check($sformatf("row%0d_gnt0", i), {31'd0, m0_if.gnt}, {31'd0, v.g0});
    check($sformatf("row%0d_gnt1", i), {31'd0, m1_if.gnt}, {31'd0, v.g1});
    check($sformatf("row%0d_mem_we", i), {31'd0, mem_we}, {31'd0, (v.g0 & v.w0) | (v.g1 & v.w1)});
    check($sformatf("row%0d_mem_addr", i), mem_addr, v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'h0));
    @(posedge clk); #1;
    check($sformatf("row%0d_rvalid0", i), {31'd0, m0_if.rvalid}, {31'd0, v.g0 & ~v.w0});
    check($sformatf("row%0d_rvalid1", i), {31'd0, m1_if.rvalid}, {31'd0, v.g1 & ~v.w1});
  endtask

  // Reference model state for the random phase.
  logic        ref_last;
  int          ref_streak;
  bit   [31:0] ref_mem [256];
  logic        ref_rv0, ref_rv1;
  logic [31:0] ref_rd0, ref_rd1;

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic p0, p1, e0, e1, both;
    logic [31:0] c0a, c0d, c1a, c1d;
    logic c0w, c1w;

    // ---------------- reset with both masters requesting ----------------
    rst_n = 1'b0;
    drive0(1'b1, 1'b1, 32'h10, 32'h1111_1111);
    drive1(1'b1, 1'b1, 32'h14, 32'h2222_2222);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gnt0", {31'd0, m0_if.gnt}, 32'd0);
    check("rst_gnt1", {31'd0, m1_if.gnt}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_rvalid0", {31'd0, m0_if.rvalid}, 32'd0);
    check("rst_rvalid1", {31'd0, m1_if.rvalid}, 32'd0);
    check("rst_rdata0", m0_if.rdata, 32'd0);
    check("rst_rdata1", m1_if.rdata, 32'd0);
    check("rst_last", {31'd0, dut.last_q}, 32'd1);
    check("rst_mem_10", tb_mem[4], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- vector table ----------------
    vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1};
    for (int i = 2; i < 12; i++) begin
      logic m1_wins;
`ifdef DMEM_ARB_RR_EN
      m1_wins = ((i - 2) % 2) == 1;
`else
      m1_wins = (i == 6) || (i == 11);
`endif
      vecs[i] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, ~m1_wins, m1_wins};
    end

    run_row(0);
    run_row(1);
    check("wr_rd_m1_rdata", m1_if.rdata, 32'hDEAD_BEEF);
    check("loser_m0_rdata", m0_if.rdata, 32'h0);
    check("mem_10_written", tb_mem[4], 32'hDEAD_BEEF);
    for (int i = 2; i < 12; i++) run_row(i);

    // ---------------- m1 alone, three back-to-back reads ----------------
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive1(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      check($sformatf("m1_alone%0d_gnt", k), {31'd0, m1_if.gnt}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("m1_alone%0d_rvalid", k), {31'd0, m1_if.rvalid}, 32'd1);
      check($sformatf("m1_alone%0d_rdata", k), m1_if.rdata, 32'hDEAD_BEEF);
    end
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_mem_addr", mem_addr, 32'h0);
    check("idle_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    check("m1_alone_rvalid_end", {31'd0, m1_if.rvalid}, 32'd0);

    // ---------------- reset during a granted read ----------------
    drive1(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("midrst_rd_gnt", {31'd0, m1_if.gnt}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_gnt_drop", {31'd0, m1_if.gnt}, 32'd0);
    @(posedge clk); #1;
    check("midrst_rvalid1", {31'd0, m1_if.rvalid}, 32'd0);
    check("midrst_rdata1", m1_if.rdata, 32'd0);
    check("midrst_last", {31'd0, dut.last_q}, 32'd1);
    rst_n = 1'b1;
    drive1(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- reset during a granted write ----------------
    drive0(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge clk);
    check("midrst_wr_we_before", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("midrst_wr_mem", tb_mem[4], 32'hDEAD_BEEF);
    rst_n = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- hold counter / first contest after reset ----------------
`ifdef DMEM_ARB_RR_EN
    drive0(1'b1, 1'b0, 32'h20, 32'h0);
    drive1(1'b1, 1'b0, 32'h24, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_first%0d_gnt0", k), {31'd0, m0_if.gnt}, {31'd0, (k % 2) == 0});
      check($sformatf("rr_first%0d_gnt1", k), {31'd0, m1_if.gnt}, {31'd0, (k % 2) == 1});
      @(posedge clk); #1;
    end
`else
    drive0(1'b1, 1'b0, 32'h20, 32'h0);
    drive1(1'b1, 1'b0, 32'h24, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_pre%0d_gnt0", k), {31'd0, m0_if.gnt}, 32'd1);
      @(posedge clk); #1;
    end
    check("hold_cnt_3", {28'd0, dut.hold_cnt_q}, 32'd3);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("hold_drop_gnt0", {31'd0, m0_if.gnt}, 32'd1);
    @(posedge clk); #1;
    check("hold_cnt_clear", {28'd0, dut.hold_cnt_q}, 32'd0);
    drive1(1'b1, 1'b0, 32'h24, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold_post%0d_gnt1", k), {31'd0, m1_if.gnt}, {31'd0, k == 4});
      @(posedge clk); #1;
    end
`endif
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- randomized traffic vs reference model ----------------
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_last = 1'b1; ref_streak = 0;
    ref_rv0 = 1'b0; ref_rv1 = 1'b0; ref_rd0 = 32'h0; ref_rd1 = 32'h0;
    p0 = 1'b0; p1 = 1'b0; e0 = 1'b0; e1 = 1'b0;
    c0a = 32'h0; c0d = 32'h0; c1a = 32'h0; c1d = 32'h0; c0w = 1'b0; c1w = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Masters: new command after a grant or when idle; rarely withdraw.
      if (!p0 || e0) begin
        p0 = $urandom_range(0, 9) < 6;
        c0w = $urandom_range(0, 1) == 1;
        c0a = 32'h80 + 32'($urandom_range(0, 15)) * 32'd4;
        c0d = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        p0 = 1'b0;
      end
      if (!p1 || e1) begin
        p1 = $urandom_range(0, 9) < 6;
        c1w = $urandom_range(0, 1) == 1;
        c1a = 32'h80 + 32'($urandom_range(0, 15)) * 32'd4;
        c1d = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        p1 = 1'b0;
      end
      drive0(p0, c0w, c0a, c0d);
      drive1(p1, c1w, c1a, c1d);

      // Expected winner from the arbitration rules.
      both = p0 && p1;
      if (both) begin
`ifdef DMEM_ARB_RR_EN
        e1 = (ref_last == 1'b0);
`else
        e1 = (ref_streak == MAX_HOLD);
`endif
        e0 = !e1;
      end else begin
        e0 = p0; e1 = p1;
      end

      @(negedge clk);
      check("rnd_gnt0", {31'd0, m0_if.gnt}, {31'd0, e0});
      check("rnd_gnt1", {31'd0, m1_if.gnt}, {31'd0, e1});
      check("rnd_mem_we", {31'd0, mem_we}, {31'd0, (e0 && c0w) || (e1 && c1w)});
      check("rnd_mem_addr", mem_addr, e0 ? c0a : (e1 ? c1a : 32'h0));
      check("rnd_mem_wdata", mem_wdata, e0 ? c0d : (e1 ? c1d : 32'h0));

      ref_rv0 = e0 && !c0w;
      ref_rv1 = e1 && !c1w;
      if (ref_rv0) ref_rd0 = ref_mem[c0a[9:2]];
      if (ref_rv1) ref_rd1 = ref_mem[c1a[9:2]];
      if (e0 && c0w) ref_mem[c0a[9:2]] = c0d;
      if (e1 && c1w) ref_mem[c1a[9:2]] = c1d;
      if (e0) ref_last = 1'b0;
      if (e1) ref_last = 1'b1;
      ref_streak = (both && e0) ? ref_streak + 1 : 0;

      @(posedge clk); #1;
      check("rnd_rvalid0", {31'd0, m0_if.rvalid}, {31'd0, ref_rv0});
      check("rnd_rvalid1", {31'd0, m1_if.rvalid}, {31'd0, ref_rv1});
      check("rnd_rdata0", m0_if.rdata, ref_rd0);
      check("rnd_rdata1", m1_if.rdata, ref_rd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter sharing the data memory's single read/write port (we/rwa/wd/rwd) between the CPU data path and an auxiliary master (pong game-state engine / loader). It arbitrates every cycle, grants one single-cycle access and muxes that master onto the memory port. Read data is registered back to the winner. The memory's read-only display port (roa) is not touched.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_HOLD, 4, max consecutive contested grants to m0 before m1 is forced (fixed-priority mode); range 1..15
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; held with its command until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  access performed this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after a granted read
- m0_rdata / m1_rdata  out  DW  registered read data
- mem_we  out  1  to memory we
- mem_addr  out  AW  to memory rwa
- mem_wdata  out  DW  to memory wd
- mem_rdata  in  DW  from memory rwd; combinational read of mem_addr

## Operation
- At most one gnt high per cycle; gnt only with matching req.
- Granted master's we/addr/wdata drive mem_*; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
- Write: memory writes at the clock edge ending the grant cycle.
- Read: mem_rdata captured into the winner's rdata at that edge; its rvalid pulses the next cycle; loser's rdata is unchanged.
- Master must hold req and command stable until it sees gnt. It may drop req (no grant) without error. A granted master with req still high next cycle is a new request.
- Registered state: last (0=m0, 1=m1, last winner), hold_cnt (4 bits).
- Single requester: granted immediately.
- Both requesting (fixed priority): m0 wins unless hold_cnt == MAX_HOLD, then m1 wins.
- hold_cnt increments when m0 wins a contested cycle. It clears when m1 wins or when m1_req is low. It saturates at MAX_HOLD.
- CPU stalls its PC and register writes while m0_req && !m0_gnt.

## Timing
- Reset (async assert): last=1, hold_cnt=0, m*_rvalid=0, m*_rdata=0.
- While reset is low, m*_gnt=0 and mem_we=0 regardless of req.
- Grant latency: 0 cycles for an uncontested request. A contested m1 waits at most MAX_HOLD cycles in fixed mode, or 1 cycle in RR mode.
- Read latency: rdata/rvalid exactly 1 cycle after gnt.
- Back-to-back grants to the same master are allowed every cycle. Consecutive reads give consecutive rvalid pulses.
- Reset asserted mid-access: the in-flight rvalid is dropped. The write of the current cycle is suppressed (mem_we forced 0).
- Reset deassertion is synchronous to clk by the top-level reset synchronizer. The first grant is possible in the first cycle with reset high.

## Configuration
- DMEM_ARB_RR_EN defined: round robin. On contest, the winner is the master that is not `last`, so the first contest after reset goes to m0. hold_cnt and MAX_HOLD are unused, and the counter is removed.
- Undefined: fixed m0 priority with MAX_HOLD anti-starvation as above.

## Structure
- Shared package: master index constants (M_CPU=0, M_AUX=1) and the default AW/DW constants, reused by the memory and top level.
- Sub-module dmem_arb_pick: combinational grant decision from req pair, last, hold_cnt and mode. The top module holds the state registers, the mem mux and the read-return registers.

## Test plan
- Reset check: reset low with both reqs high → both gnt=0, mem_we=0, rvalid=0, rdata=0, last=1.
- m0 write 0x0000_0010 ← 0xDEAD_BEEF, then m1 read of 0x10 → m1_gnt same cycle as m1_req, m1_rvalid next cycle, m1_rdata=0xDEAD_BEEF.
- Fixed mode, MAX_HOLD=4, both reqs held high for 10 cycles → gnt pattern m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
- DMEM_ARB_RR_EN, both reqs held high → m0,m1,m0,m1…; m1 alone for 3 cycles → three m1 grants and three m1_rvalid pulses, one cycle delayed.
- m1 read granted, then reset asserted before the next edge → m1_rvalid stays 0. m0 write in the same cycle as reset assertion → memory location unchanged.
- m1_req dropped after a contested cycle with hold_cnt=3 → hold_cnt=0. On the next contest, m0 wins 4 more times before m1.
